// File: rtl/button_conditioner_if.sv
// Push-button conditioner bus: raw active-low button in, clean levels and strobes out.
interface button_conditioner_if;
  logic button_n;
  logic pressed;
  logic held;
  logic press_pulse;
  logic release_pulse;
  logic step_pulse;

  // Board/bench side: drives the raw button, consumes conditioned outputs.
  modport master (
    output button_n,
    input  pressed,
    input  held,
    input  press_pulse,
    input  release_pulse,
    input  step_pulse
  );

  // Conditioner side.
  modport slave (
    input  button_n,
    output pressed,
    output held,
    output press_pulse,
    output release_pulse,
    output step_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces an active-low push-button and emits press/release strobes
// plus an auto-repeat step strobe while the button stays held.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 150000000,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  localparam int unsigned RepW  = $clog2(REPEAT_CYCLES);

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StPressed,
    StHolding,
    StDebRelease
  } state_e;

  logic s1_q, s2_q;
  state_e state_q, state_d;
  // Set when DEB_RELEASE was entered from HOLDING rather than PRESSED.
  logic from_hold_q, from_hold_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
  logic pressed_q, pressed_d;
  logic held_q, held_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic step_q, step_d;
  // One counting cycle of PRESSED / HOLDING (also taken when a release glitch resolves).
  logic hold_step, rep_step;

  // Two-flop synchroniser for the asynchronous button; idles high (released).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= bus.button_n;
      s2_q <= s1_q;
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    from_hold_d = from_hold_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    step_d      = 1'b0;
    hold_step   = 1'b0;
    rep_step    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!s2_q) begin
          state_d   = StDebPress;
          deb_cnt_d = '0;
        end
      end
      StDebPress: begin
        if (s2_q) begin
          state_d = StIdle;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StPressed;
          deb_cnt_d  = '0;
          hold_cnt_d = '0;
          press_d    = 1'b1;
          step_d     = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (s2_q) begin
          state_d     = StDebRelease;
          deb_cnt_d   = '0;
          from_hold_d = 1'b0;
        end else begin
          hold_step = 1'b1;
        end
      end
      StHolding: begin
        // Release wins over a coincident repeat tick.
        if (s2_q) begin
          state_d     = StDebRelease;
          deb_cnt_d   = '0;
          from_hold_d = 1'b1;
        end else begin
          rep_step = 1'b1;
        end
      end
      StDebRelease: begin
        if (!s2_q) begin
          // Glitch: resume the origin counter so the delay equals the glitch length.
          deb_cnt_d = '0;
          if (from_hold_q) rep_step = 1'b1;
          else             hold_step = 1'b1;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StIdle;
          deb_cnt_d  = '0;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
          release_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (hold_step) begin
      if (hold_cnt_q == HoldLast) begin
        state_d    = StHolding;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        step_d     = 1'b1;
      end else begin
        state_d    = StPressed;
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end

    if (rep_step) begin
      state_d = StHolding;
      if (rep_cnt_q == RepLast) begin
        rep_cnt_d = '0;
        step_d    = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end

    pressed_d = (state_d == StPressed) || (state_d == StHolding) || (state_d == StDebRelease);
    held_d    = (state_d == StHolding) || ((state_d == StDebRelease) && from_hold_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      from_hold_q <= 1'b0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      pressed_q   <= 1'b0;
      held_q      <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      from_hold_q <= from_hold_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      pressed_q   <= pressed_d;
      held_q      <= held_d;
      press_q     <= press_d;
      release_q   <= release_d;
      step_q      <= step_d;
    end
  end

  assign bus.pressed       = pressed_q;
  assign bus.held          = held_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.step_pulse    = step_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected strobe cycles go into per-strobe queues
// when the stimulus is driven and are popped as the strobes appear.
module tb_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned H = 10;
  localparam int unsigned R = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;  // posedges seen so far
  // Expected strobe cycles: 0 = press_pulse, 1 = release_pulse, 2 = step_pulse.
  int exp_q [3][$];

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic mon_kind(input int k, input logic obs, input string tag);
    logic due;
    due = (exp_q[k].size() > 0) && (exp_q[k][0] == cyc);
    if (due) void'(exp_q[k].pop_front());
    if (obs || due) chk($sformatf("%s@%0d", tag, cyc), obs, due);
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    mon_kind(0, bus.press_pulse, "press_pulse");
    mon_kind(1, bus.release_pulse, "release_pulse");
    mon_kind(2, bus.step_pulse, "step_pulse");
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_press(input int c);
    exp_q[0].push_back(c);
    exp_q[2].push_back(c);
  endtask

  initial begin
    int n;
    int p;
    int rel;

    bus.button_n = 1'b1;
    rst = 1'b1;
    tick(); tick(); tick();
    chk("reset_pressed", bus.pressed, 1'b0);
    chk("reset_held", bus.held, 1'b0);
    chk("reset_press_pulse", bus.press_pulse, 1'b0);
    chk("reset_release_pulse", bus.release_pulse, 1'b0);
    chk("reset_step_pulse", bus.step_pulse, 1'b0);
    rst = 1'b0;
    tick(); tick();

    // Clean press, auto-repeat, release glitch in HOLDING, clean release.
    bus.button_n = 1'b0;
    n = cyc + 1;
    p = n + 2 + D;
    expect_press(p);
    exp_q[2].push_back(p + H);
    exp_q[2].push_back(p + H + R);
    exp_q[2].push_back(p + H + 2 * R);
    exp_q[2].push_back(p + H + 3 * R + 2);  // delayed by the 2-cycle glitch
    exp_q[2].push_back(p + H + 4 * R + 2);
    run_to(p - 1);
    chk("pressed_before_accept", bus.pressed, 1'b0);
    run_to(p);
    chk("pressed_at_accept", bus.pressed, 1'b1);
    chk("held_at_accept", bus.held, 1'b0);
    run_to(p + H - 1);
    chk("held_before_repeat", bus.held, 1'b0);
    run_to(p + H);
    chk("held_at_repeat", bus.held, 1'b1);
    chk("pressed_at_repeat", bus.pressed, 1'b1);

    run_to(p + H + 2 * R + 2);
    bus.button_n = 1'b1;
    tick(); tick();
    bus.button_n = 1'b0;
    run_to(p + H + 3 * R);
    chk("held_in_glitch_a", bus.held, 1'b1);
    chk("pressed_in_glitch", bus.pressed, 1'b1);
    tick();
    chk("held_in_glitch_b", bus.held, 1'b1);

    run_to(p + H + 4 * R + 3);
    bus.button_n = 1'b1;
    n = cyc + 1;
    rel = n + 2 + D;
    exp_q[1].push_back(rel);
    run_to(rel - 1);
    chk("pressed_before_release", bus.pressed, 1'b1);
    chk("held_before_release", bus.held, 1'b1);
    run_to(rel);
    chk("pressed_at_release", bus.pressed, 1'b0);
    chk("held_at_release", bus.held, 1'b0);

    // Bounce: low 3, high 1, low 3, high -> nothing accepted.
    run_to(rel + 3);
    bus.button_n = 1'b0;
    tick(); tick(); tick();
    bus.button_n = 1'b1;
    tick();
    bus.button_n = 1'b0;
    tick(); tick(); tick();
    chk("bounce_pressed_mid", bus.pressed, 1'b0);
    bus.button_n = 1'b1;
    run_to(cyc + 10);
    chk("bounce_pressed_end", bus.pressed, 1'b0);

    // Short press released before the hold threshold.
    bus.button_n = 1'b0;
    n = cyc + 1;
    p = n + 2 + D;
    expect_press(p);
    run_to(p + 2);
    bus.button_n = 1'b1;
    n = cyc + 1;
    rel = n + 2 + D;
    exp_q[1].push_back(rel);
    run_to(rel - 1);
    chk("short_pressed_before_release", bus.pressed, 1'b1);
    chk("short_held", bus.held, 1'b0);
    run_to(rel);
    chk("short_pressed_at_release", bus.pressed, 1'b0);

    // Reset while in HOLDING with the button still down.
    run_to(cyc + 3);
    bus.button_n = 1'b0;
    n = cyc + 1;
    p = n + 2 + D;
    expect_press(p);
    exp_q[2].push_back(p + H);
    run_to(p + H + 2);
    chk("held_before_reset", bus.held, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_pressed", bus.pressed, 1'b0);
    chk("midreset_held", bus.held, 1'b0);
    chk("midreset_step", bus.step_pulse, 1'b0);
    n = cyc + 1;
    p = n + 2 + D;
    expect_press(p);
    run_to(p - 1);
    chk("repress_pressed_before", bus.pressed, 1'b0);
    run_to(p);
    chk("repress_pressed_at", bus.pressed, 1'b1);
    run_to(p + 3);
    bus.button_n = 1'b1;
    n = cyc + 1;
    rel = n + 2 + D;
    exp_q[1].push_back(rel);
    run_to(rel + 4);
    chk("final_pressed", bus.pressed, 1'b0);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("queue_%0d_drained", k), exp_q[k].size() == 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
